// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default widths,
// read-source selector and a helper to pull one port out of a packed bus.
package rf_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Widest packed port bus and widest single field the slice helper handles
  localparam int MAX_VEC   = 256;
  localparam int MAX_SLICE = 64;

  typedef enum logic [1:0] {
    RD_ZERO  = 2'd0,
    RD_WP0   = 2'd1,
    RD_WP1   = 2'd2,
    RD_ARRAY = 2'd3
  } rd_src_e;

  function automatic logic [MAX_SLICE-1:0] get_slice(input logic [MAX_VEC-1:0] vec,
                                                     input int idx,
                                                     input int width);
    return MAX_SLICE'(vec >> (idx * width));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: write ports, busy-set request,
// read ports and the scoreboard snapshot.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);

  logic [1:0]                   wen;
  logic [2*ADDR_WIDTH-1:0]      waddr;
  logic [2*DATA_WIDTH-1:0]      wdata;
  logic                         set_en;
  logic [ADDR_WIDTH-1:0]        set_addr;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rready;
  logic [2**ADDR_WIDTH-1:0]     busy_vec;

  modport master (
    output wen, waddr, wdata, set_en, set_addr, raddr,
    input  rdata, rready, busy_vec
  );

  modport slave (
    input  wen, waddr, wdata, set_en, set_addr, raddr,
    output rdata, rready, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its
// result is written back; a fresh producer beats a same-edge clear.
module rf_scoreboard #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               wen,
  input  logic [ADDR_WIDTH-1:0]    waddr0,
  input  logic [ADDR_WIDTH-1:0]    waddr1,
  input  logic                     set_en,
  input  logic [ADDR_WIDTH-1:0]    set_addr,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);

  logic [2**ADDR_WIDTH-1:0] busy;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  // Clears first, then the set, so the new producer supersedes the old one
  always_comb begin
    busy_next = busy;
    if (wen[0]) busy_next[waddr0] = 1'b0;
    if (wen[1]) busy_next[waddr1] = 1'b0;
    if (set_en && (set_addr != '0)) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, optional same-cycle
// bypass, register 0 hardwired to zero and a busy scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic [ADDR_WIDTH-1:0]        wa  [2];
  logic [DATA_WIDTH-1:0]        wd  [2];
  logic [DEPTH-1:0]             busy;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_all;
  logic [NUM_RD-1:0]            rready_all;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa[p] = ADDR_WIDTH'(get_slice(MAX_VEC'(bus.waddr), p, ADDR_WIDTH));
      wd[p] = DATA_WIDTH'(get_slice(MAX_VEC'(bus.wdata), p, DATA_WIDTH));
    end
  end

  // Port 1 is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.wen[p] && (wa[p] != '0)) mem[wa[p]] <= wd[p];
      end
    end
  end

  rf_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wen      (bus.wen),
    .waddr0   (wa[0]),
    .waddr1   (wa[1]),
    .set_en   (bus.set_en),
    .set_addr (bus.set_addr),
    .busy_vec (busy)
  );

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    rd_src_e               src;
    logic [DATA_WIDTH-1:0] data;
    logic                  rdy;

    assign ra = ADDR_WIDTH'(get_slice(MAX_VEC'(bus.raddr), r, ADDR_WIDTH));

    // Forwarded data is by definition ready, whatever the busy bit says
    always_comb begin
      src = RD_ARRAY;
      if (ra == '0)
        src = RD_ZERO;
      else if ((BYPASS != 0) && bus.wen[1] && (wa[1] == ra))
        src = RD_WP1;
      else if ((BYPASS != 0) && bus.wen[0] && (wa[0] == ra))
        src = RD_WP0;
    end

    always_comb begin
      data = '0;
      rdy  = 1'b1;
      case (src)
        RD_ZERO:  begin data = '0;      rdy = 1'b1;      end
        RD_WP0:   begin data = wd[0];   rdy = 1'b1;      end
        RD_WP1:   begin data = wd[1];   rdy = 1'b1;      end
        default:  begin data = mem[ra]; rdy = ~busy[ra]; end
      endcase
    end

    assign rdata_all[r*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rready_all[r]                         = rdy;
  end

  assign bus.rdata    = rdata_all;
  assign bus.rready   = rready_all;
  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: a bypassing and a non-bypassing register file see the
// same directed stimulus; expected read/busy values are queued per cycle.
module tb_reg_file_mp;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int K_RDATA  = 0;
  localparam int K_RREADY = 1;
  localparam int K_BUSY   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    wen;
  logic [AW-1:0] waddr0, waddr1, set_addr, raddr0, raddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          set_en;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus_b ();
  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus_n ();

  assign bus_b.wen      = wen;
  assign bus_b.waddr    = {waddr1, waddr0};
  assign bus_b.wdata    = {wdata1, wdata0};
  assign bus_b.set_en   = set_en;
  assign bus_b.set_addr = set_addr;
  assign bus_b.raddr    = {raddr1, raddr0};
  assign bus_n.wen      = wen;
  assign bus_n.waddr    = {waddr1, waddr0};
  assign bus_n.wdata    = {wdata1, wdata0};
  assign bus_n.set_en   = set_en;
  assign bus_n.set_addr = set_addr;
  assign bus_n.raddr    = {raddr1, raddr0};

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nb (
    .clk (clk), .rst (rst), .bus (bus_n)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cycle++;

  function automatic logic [31:0] actual(input int dut, input int kind, input int port);
    logic [31:0] v;
    v = '0;
    if (dut == 0) begin
      case (kind)
        K_RDATA:  v = bus_b.rdata[port*DW +: DW];
        K_RREADY: v = {31'd0, bus_b.rready[port]};
        default:  v = bus_b.busy_vec;
      endcase
    end else begin
      case (kind)
        K_RDATA:  v = bus_n.rdata[port*DW +: DW];
        K_RREADY: v = {31'd0, bus_n.rready[port]};
        default:  v = bus_n.busy_vec;
      endcase
    end
    return v;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [31:0] got;
    got = actual(e.dut, e.kind, e.port);
    checks++;
    if (got !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s (%s, cycle %0d): got 0x%0h, expected 0x%0h",
               e.name, (e.dut == 0) ? "bypass" : "no-bypass", e.cyc, got, e.exp);
    end
  endtask

  // Monitor: pops every expectation queued for the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cycle) begin
        e = q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic se, input logic [AW-1:0] sa,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(posedge clk);
    #1;
    rst = r; wen = w; waddr0 = a0; wdata0 = d0; waddr1 = a1; wdata1 = d1;
    set_en = se; set_addr = sa; raddr0 = r0; raddr1 = r1;
  endtask

  task automatic pushExp(input int dut, input int kind, input int port,
                         input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cycle; e.dut = dut; e.kind = kind; e.port = port; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic expectRd(input int dut, input int port, input logic [31:0] d,
                          input logic rdy, input string name);
    pushExp(dut, K_RDATA, port, d, {name, "_rdata"});
    pushExp(dut, K_RREADY, port, {31'd0, rdy}, {name, "_rready"});
  endtask

  task automatic expectRdBoth(input int port, input logic [31:0] d, input logic rdy,
                              input string name);
    expectRd(0, port, d, rdy, name);
    expectRd(1, port, d, rdy, name);
  endtask

  task automatic expectBusyBoth(input logic [31:0] v, input string name);
    pushExp(0, K_BUSY, 0, v, name);
    pushExp(1, K_BUSY, 0, v, name);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; wen = 2'b00; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    set_en = 1'b0; set_addr = '0; raddr0 = '0; raddr1 = '0;

    // Out of reset: some writes and a busy set are issued
    applyStimulus(0, 2'b11, 5'd1, 32'h111, 5'd2, 32'h222, 1, 5'd6, 5'd6, 5'd3);
    expectRdBoth(0, 32'h0, 1'b1, "reset_r6");
    expectRdBoth(1, 32'h0, 1'b1, "reset_r3");
    expectBusyBoth(32'h0, "reset_busy");

    // State is visible, then reset with traffic stopped
    applyStimulus(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd2);
    expectRdBoth(0, 32'h111, 1'b1, "pre_reset_r1");
    expectRdBoth(1, 32'h222, 1'b1, "pre_reset_r2");
    expectBusyBoth(32'h1 << 6, "pre_reset_busy");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd1, 5'd6);
    expectRdBoth(0, 32'h0, 1'b1, "after_reset_r1");
    expectRdBoth(1, 32'h0, 1'b1, "after_reset_r6");
    expectBusyBoth(32'h0, "after_reset_busy");

    // r5 <- DEADBEEF, bypass seen only on the bypassing build
    applyStimulus(0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd5);
    expectRd(0, 1, 32'hDEADBEEF, 1'b1, "wr_r5_bypass");
    expectRd(1, 1, 32'h0, 1'b1, "wr_r5_nobypass");

    // Write to r0 is dropped and never forwarded
    applyStimulus(0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd5);
    expectRdBoth(0, 32'h0, 1'b1, "wr_r0_bypass");
    expectRdBoth(1, 32'hDEADBEEF, 1'b1, "rd_r5");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd5);
    expectRdBoth(0, 32'h0, 1'b1, "rd_r0");
    expectRdBoth(1, 32'hDEADBEEF, 1'b1, "rd_r5_again");

    applyStimulus(0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd9);
    expectRd(0, 0, 32'hA5A5A5A5, 1'b1, "bypass_r7");
    expectRd(1, 0, 32'h0, 1'b1, "old_r7");
    expectRdBoth(1, 32'h0, 1'b1, "rd_r9_empty");

    // Both ports write r9: port 1 wins
    applyStimulus(0, 2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 0, 5'd0, 5'd9, 5'd7);
    expectRd(0, 0, 32'h22, 1'b1, "collide_bypass_r9");
    expectRd(1, 0, 32'h0, 1'b1, "collide_old_r9");
    expectRdBoth(1, 32'hA5A5A5A5, 1'b1, "rd_r7");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    expectRdBoth(0, 32'h22, 1'b1, "collide_r9");

    // Scoreboard: set r3 busy
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd3, 5'd3, 5'd9);
    expectRdBoth(0, 32'h0, 1'b1, "pre_set_r3");
    expectBusyBoth(32'h0, "pre_set_busy");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd9);
    expectRdBoth(0, 32'h0, 1'b0, "busy_r3");
    expectRdBoth(1, 32'h22, 1'b1, "r9_not_busy");
    expectBusyBoth(32'h1 << 3, "set_busy_r3");

    applyStimulus(0, 2'b01, 5'd3, 32'h3333, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0);
    expectRd(0, 0, 32'h3333, 1'b1, "wb_bypass_r3");
    expectRd(1, 0, 32'h0, 1'b0, "wb_nobypass_r3");
    expectBusyBoth(32'h1 << 3, "wb_busy_still");

    // Clear and set of r3 on one edge: set wins
    applyStimulus(0, 2'b10, 5'd0, 32'h0, 5'd3, 32'h4444, 1, 5'd3, 5'd3, 5'd0);
    expectRd(0, 0, 32'h4444, 1'b1, "setclr_bypass_r3");
    expectRd(1, 0, 32'h3333, 1'b1, "setclr_nobypass_r3");
    expectBusyBoth(32'h0, "cleared_busy");

    // set_addr 0 is ignored
    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd0, 5'd3, 5'd0);
    expectRdBoth(0, 32'h4444, 1'b0, "set_wins_r3");
    expectBusyBoth(32'h1 << 3, "set_wins_busy");

    // Reset with a set and write to r4 in flight
    applyStimulus(1, 2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 1, 5'd4, 5'd3, 5'd0);
    expectRdBoth(0, 32'h4444, 1'b0, "set_r0_ignored_r3");
    expectBusyBoth(32'h1 << 3, "set_r0_ignored_busy");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd10, 5'd4, 5'd3);
    expectRdBoth(0, 32'h0, 1'b1, "midreset_r4");
    expectRdBoth(1, 32'h0, 1'b1, "midreset_r3");
    expectBusyBoth(32'h0, "midreset_busy");

    // Busy clear through write port 1
    applyStimulus(0, 2'b10, 5'd0, 32'h0, 5'd10, 32'hBEEF, 0, 5'd0, 5'd10, 5'd0);
    expectRd(0, 0, 32'hBEEF, 1'b1, "p1_bypass_r10");
    expectRd(1, 0, 32'h0, 1'b0, "p1_nobypass_r10");
    expectBusyBoth(32'h1 << 10, "p1_busy_r10");

    applyStimulus(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd10, 5'd0);
    expectRdBoth(0, 32'hBEEF, 1'b1, "p1_r10");
    expectBusyBoth(32'h0, "p1_cleared_busy");

    repeat (3) @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never compared, expected 0x%0h", e.name, e.exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with a per-register busy scoreboard: N combinational read ports, two write ports with same-cycle bypass, and register 0 hardwired to zero. Sits in the decode/writeback path of the pipelined CPU. Decode reads operands and checks hazards; writeback and a second retire path commit results. A register is marked busy when a producer issues and cleared when its result is written.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wen  in  2  write enable per write port (bit 0 = port 0, bit 1 = port 1)
- waddr  in  2*ADDR_WIDTH  write addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  in  2*DATA_WIDTH  write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
- set_en  in  1  mark set_addr busy (producer issued)
- set_addr  in  ADDR_WIDTH  register to mark busy
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses, packed per port
- rdata  out  NUM_RD*DATA_WIDTH  read data, packed per port
- rready  out  NUM_RD  1 = rdata on that port is valid (no pending producer)
- busy_vec  out  2**ADDR_WIDTH  scoreboard state, bit i = register i busy

## Operation
- Reset: on a rising edge with rst=1, all registers clear to 0 and all busy bits clear. wen and set_en are ignored that edge. Reset mid-operation discards in-flight writes and sets.
- Write: on a rising edge with wen[p]=1 and waddr_p≠0, register waddr_p ← wdata_p. Writes to address 0 are dropped.
- Dual write, same address: port 1 wins for both the array and the bypass.
- Busy clear: wen[p]=1 clears busy[waddr_p] on the same edge.
- Busy set: set_en=1 with set_addr≠0 sets busy[set_addr]. Set and clear of the same address on one edge: set wins, because a new producer supersedes the old one. set_addr=0 is ignored; busy[0] is constantly 0.
- Read, per port r, combinational:
  - raddr_r=0 → rdata_r=0, rready_r=1.
  - Else if BYPASS=1 and wen[p]=1 with waddr_p=raddr_r → rdata_r=wdata_p (port 1 priority), rready_r=1.
  - Else rdata_r=array[raddr_r], rready_r=~busy[raddr_r].
- With BYPASS=0, a same-cycle write is not visible. rdata shows the old value and rready follows the current busy bit.
- No arithmetic; all widths are exact. Addresses wrap naturally within 2**ADDR_WIDTH.

## Timing
- Read latency 0 cycles (combinational from raddr, array, busy, and the write ports when BYPASS=1).
- Write latency 1 edge; with BYPASS=1 the value is visible in the same cycle.
- busy_vec is registered and updates 1 edge after set_en or wen.
- Output values after the reset edge: rdata=0 for every port, rready all 1, busy_vec=0. Before the first reset edge, contents are undefined.
- rst takes priority over every other input on the same edge.

## Structure
- Shared package rf_pkg holds the DATA_WIDTH/ADDR_WIDTH defaults and a function to extract packed port slices.
- Sub-module rf_scoreboard holds the busy bit vector with set/clear priority logic and the busy_vec output. The top holds the storage array, the write-port priority logic, and NUM_RD instances of generated read/bypass muxes.

## Test plan
- Reset: with rst=1 for 1 cycle after random writes → all reads 0, rready all 1, busy_vec=0.
- Basic write/read: write 0xDEADBEEF to r5 on port 0, then read r5 on port 1 the next cycle → 0xDEADBEEF, rready=1. Write 0x1234 to r0 → r0 reads 0.
- Bypass: BYPASS=1, same cycle wen=01, waddr0=7, wdata0=0xA5A5A5A5, raddr0=7 → rdata0=0xA5A5A5A5 combinationally. BYPASS=0 build → old value.
- Dual-write collision: both ports write r9 (port 0 0x11, port 1 0x22) → same-cycle bypass 0x22, next-cycle read 0x22.
- Scoreboard: set_en r3 → next cycle busy_vec[3]=1, rready=0 for raddr=3. Write r3 → bypassed read rready=1, busy clear next cycle. set_en r3 and write r3 on the same edge → busy stays 1.
- Reset mid-operation: set_en r4 and write r4=0x55 on the same edge as rst=1 → r4=0, busy_vec[4]=0.
